rx_os_decoder: RTL and testbench

// Per-lane receive-side Ordered-Set decoder for Gen1/Gen2 (8b/10b) links; the receive counterpart of the TX OS generator.

---
 rtl/rx_os_decoder_pkg.sv | 161 ++++++++++++++++
 rtl/rx_os_decoder.sv | 150 +++++++++++++++
 tb/tb_rx_os_decoder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_os_decoder_pkg.sv
// Shared ordered-set definitions for the per-lane RX OS decoder: 8b/10b
// K-codes, TS identifiers, FSM state encoding, the decoder context that is
// carried from symbol to symbol, and the single-symbol FSM step function.
package rx_os_decoder_pkg;

  // K-codes (valid only with the K flag set)
  localparam logic [7:0] K_COM = 8'hBC;  // K28.5
  localparam logic [7:0] K_PAD = 8'hF7;  // K23.7
  localparam logic [7:0] K_SKP = 8'h1C;  // K28.0
  localparam logic [7:0] K_IDL = 8'h7C;  // K28.3

  // TS identifier symbols (D-codes)
  localparam logic [7:0] TS1_ID = 8'h4A;  // D10.2
  localparam logic [7:0] TS2_ID = 8'h45;  // D5.2

  // PIPE RxStatus value for an 8b/10b decode error
  localparam logic [2:0] RX_DECODE_ERR = 3'b100;

  // Symbol index of the last symbol of each OS type
  localparam logic [3:0] TS_LAST_IDX   = 4'd15;
  localparam logic [3:0] EIOS_LAST_IDX = 4'd3;
  localparam logic [3:0] HDR_LAST_IDX  = 4'd5;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_COM1  = 3'd1,
    ST_TSHDR = 3'd2,
    ST_TSID  = 3'd3,
    ST_EIOS  = 3'd4,
    ST_SKP   = 3'd5
  } os_state_e;

  // Decoded TS fields; the whole struct is the identity used by the
  // consecutive-TS comparison.
  typedef struct packed {
    logic       ts_type;    // 0 = TS1, 1 = TS2
    logic       link_pad;
    logic [7:0] link_num;
    logic       lane_pad;
    logic [7:0] lane_num;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctl;
  } ts_fields_t;

  // Everything the FSM needs between symbols: state, index of the next
  // expected symbol, and the shadow copy of the TS under construction.
  typedef struct packed {
    os_state_e  state;
    logic [3:0] idx;
    ts_fields_t shadow;
  } os_ctx_t;

  // Result of consuming one symbol.
  typedef struct packed {
    os_ctx_t ctx;
    logic    ts_done;
    logic    eios_done;
    logic    err;
  } step_t;

  localparam os_ctx_t CTX_RESET = '{state: ST_HUNT, idx: 4'd0, shadow: '0};

  // State a symbol leads to when seen in HUNT: only a COM starts an OS.
  function automatic os_state_e hunt_state(input logic [7:0] sym, input logic k);
    return (k && (sym == K_COM)) ? ST_COM1 : ST_HUNT;
  endfunction

  // One FSM step for one received symbol. A violation discards the shadow
  // and re-evaluates the offending symbol as if in HUNT, so a COM that
  // breaks an OS immediately starts the next one.
  function automatic step_t os_step(input os_ctx_t cur, input logic [7:0] sym,
                                    input logic k);
    step_t r;
    logic  bad;
    r.ctx       = cur;
    r.ts_done   = 1'b0;
    r.eios_done = 1'b0;
    r.err       = 1'b0;
    bad         = 1'b0;

    case (cur.state)
      ST_HUNT: r.ctx.state = hunt_state(sym, k);

      ST_COM1: begin
        if (k && (sym == K_IDL)) begin
          r.ctx.state = ST_EIOS;
          r.ctx.idx   = 4'd2;
        end else if (k && (sym == K_SKP)) begin
          r.ctx.state = ST_SKP;
        end else if (!k || (sym == K_PAD)) begin
          // This symbol is TS symbol 1 (link number or PAD).
          r.ctx.state           = ST_TSHDR;
          r.ctx.idx             = 4'd2;
          r.ctx.shadow          = '0;
          r.ctx.shadow.link_pad = k;
          r.ctx.shadow.link_num = k ? 8'h00 : sym;
        end else begin
          bad = 1'b1;
        end
      end

      ST_TSHDR: begin
        // Symbol 2 may be PAD; symbols 3-5 must be data.
        bad = (cur.idx == 4'd2) ? (k && (sym != K_PAD)) : k;
        case (cur.idx)
          4'd2: begin
            r.ctx.shadow.lane_pad = k;
            r.ctx.shadow.lane_num = k ? 8'h00 : sym;
          end
          4'd3:    r.ctx.shadow.n_fts     = sym;
          4'd4:    r.ctx.shadow.rate_id   = sym;
          default: r.ctx.shadow.train_ctl = sym;
        endcase
        r.ctx.idx = cur.idx + 4'd1;
        if (cur.idx == HDR_LAST_IDX) r.ctx.state = ST_TSID;
      end

      ST_TSID: begin
        if (cur.idx == 4'd6) begin
          // Symbol 6 fixes the TS type for the rest of the identifier run.
          bad = k || ((sym != TS1_ID) && (sym != TS2_ID));
          r.ctx.shadow.ts_type = (sym == TS2_ID);
        end else begin
          bad = k || (sym != (cur.shadow.ts_type ? TS2_ID : TS1_ID));
        end
        r.ctx.idx = cur.idx + 4'd1;
        if (cur.idx == TS_LAST_IDX) begin
          r.ctx.state = ST_HUNT;
          r.ctx.idx   = 4'd0;
          r.ts_done   = !bad;
        end
      end

      ST_EIOS: begin
        bad       = !(k && (sym == K_IDL));
        r.ctx.idx = cur.idx + 4'd1;
        if (cur.idx == EIOS_LAST_IDX) begin
          r.ctx.state = ST_HUNT;
          r.ctx.idx   = 4'd0;
          r.eios_done = !bad;
        end
      end

      ST_SKP: begin
        // Absorb SKPs; the first other symbol is handled as in HUNT.
        if (!(k && (sym == K_SKP))) r.ctx.state = hunt_state(sym, k);
      end

      default: r.ctx = CTX_RESET;
    endcase

    if (bad) begin
      r.ctx       = CTX_RESET;
      r.ctx.state = hunt_state(sym, k);
      r.err       = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_os_decoder.sv
// Per-lane receive Ordered-Set decoder for 8b/10b links. Walks the
// SYMS = PIPEWIDTH/8 symbols of each valid beat through the OS FSM in
// arrival order, then registers decoded TS fields, a saturating
// consecutive-identical-TS count and one-cycle event pulses.
module rx_os_decoder
  import rx_os_decoder_pkg::*;
#(
  parameter int PIPEWIDTH = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic [PIPEWIDTH-1:0]   RxData,
  input  logic [PIPEWIDTH/8-1:0] RxDataK,
  input  logic                   RxValid,
  input  logic [2:0]             RxStatus,
  output logic                   ts_valid,
  output logic                   ts_type,
  output logic [7:0]             link_num,
  output logic                   link_pad,
  output logic [7:0]             lane_num,
  output logic                   lane_pad,
  output logic [7:0]             n_fts,
  output logic [7:0]             rate_id,
  output logic [7:0]             train_ctl,
  output logic [CNT_W-1:0]       consec_cnt,
  output logic                   eios_det,
  output logic                   os_err
);

  localparam int SYMS = PIPEWIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  os_ctx_t          ctx_q, ctx_d;
  ts_fields_t       fields_q, fields_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ts_valid_q, ts_valid_d;
  logic             eios_det_q, eios_det_d;
  logic             os_err_q, os_err_d;

  // Per-symbol events of the current beat, in arrival order.
  logic [SYMS-1:0]  sym_done;
  logic [SYMS-1:0]  sym_eios;
  logic [SYMS-1:0]  sym_err;
  ts_fields_t       done_fields [SYMS];
  logic             beat_err;

  // State register: FSM context, published fields, count and pulses.
  always_ff @(posedge pclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values computed before this edge, independent of the
    // order of statements.
    if (reset) begin
      ctx_q      <= CTX_RESET;
      fields_q   <= '0;
      cnt_q      <= '0;
      ts_valid_q <= 1'b0;
      eios_det_q <= 1'b0;
      os_err_q   <= 1'b0;
    end else begin
      ctx_q      <= ctx_d;
      fields_q   <= fields_d;
      cnt_q      <= cnt_d;
      ts_valid_q <= ts_valid_d;
      eios_det_q <= eios_det_d;
      os_err_q   <= os_err_d;
    end
  end

  // Next state: walk the beat's symbols through the FSM, recording events.
  always_comb begin : next_state_comb
    os_ctx_t walk;
    step_t   st;
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    walk     = ctx_q;
    st       = '0;
    ctx_d    = ctx_q;
    sym_done = '0;
    sym_eios = '0;
    sym_err  = '0;
    beat_err = 1'b0;
    for (int i = 0; i < SYMS; i++) done_fields[i] = '0;

    if (RxValid) begin
      if (RxStatus == RX_DECODE_ERR) begin
        // A decode error poisons the whole beat; only an OS in progress
        // is reported.
        if (ctx_q.state != ST_HUNT) begin
          beat_err = 1'b1;
          ctx_d    = CTX_RESET;
        end
      end else begin
        for (int i = 0; i < SYMS; i++) begin
          st             = os_step(walk, RxData[8*i +: 8], RxDataK[i]);
          sym_done[i]    = st.ts_done;
          sym_eios[i]    = st.eios_done;
          sym_err[i]     = st.err;
          done_fields[i] = st.ctx.shadow;
          walk           = st.ctx;
        end
        ctx_d = walk;
      end
    end
  end

  // Outputs: apply the beat's events in symbol order so the later one wins.
  always_comb begin
    fields_d   = fields_q;
    cnt_d      = beat_err ? '0 : cnt_q;
    ts_valid_d = 1'b0;
    eios_det_d = 1'b0;
    os_err_d   = beat_err;

    for (int i = 0; i < SYMS; i++) begin
      if (sym_err[i]) begin
        os_err_d = 1'b1;
        cnt_d    = '0;
      end
      if (sym_done[i]) begin
        ts_valid_d = 1'b1;
        if (done_fields[i] == fields_d) begin
          cnt_d = (cnt_d == CNT_MAX) ? cnt_d : cnt_d + CNT_ONE;
        end else begin
          cnt_d = CNT_ONE;
        end
        fields_d = done_fields[i];
      end
      if (sym_eios[i]) begin
        eios_det_d = 1'b1;
        cnt_d      = '0;
      end
    end
  end

  assign ts_valid   = ts_valid_q;
  assign eios_det   = eios_det_q;
  assign os_err     = os_err_q;
  assign consec_cnt = cnt_q;
  assign ts_type    = fields_q.ts_type;
  assign link_pad   = fields_q.link_pad;
  assign link_num   = fields_q.link_num;
  assign lane_pad   = fields_q.lane_pad;
  assign lane_num   = fields_q.lane_num;
  assign n_fts      = fields_q.n_fts;
  assign rate_id    = fields_q.rate_id;
  assign train_ctl  = fields_q.train_ctl;

endmodule

// File: tb/tb_rx_os_decoder.sv
// Scoreboard bench for rx_os_decoder: an 8-bit instance (default counter)
// and a 32-bit instance with a 2-bit counter. Every OS driven pushes the
// event it should cause; monitors pop and compare on each output pulse.
module tb_rx_os_decoder;

  typedef logic [15:0][8:0] os_t;  // {K, symbol} per position; [0] is COM

  typedef struct {
    logic        ts;
    logic        eios;
    logic        err;
    logic [42:0] f;
    int          cnt;
    int          gap;
  } exp_t;

  localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, SKP = 8'h1C, IDL = 8'h7C;
  localparam logic [7:0] ID1 = 8'h4A, ID2 = 8'h45;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-bit instance
  logic [7:0]  rxd8 = '0;
  logic [0:0]  rxk8 = '0;
  logic        rxv8 = 1'b0;
  logic [2:0]  rxs8 = '0;
  logic        ts_valid8, ts_type8, link_pad8, lane_pad8, eios8, err8;
  logic [7:0]  link8, lane8, nfts8, rate8, ctl8;
  logic [3:0]  cnt8;

  // 32-bit instance
  logic [31:0] rxd32 = '0;
  logic [3:0]  rxk32 = '0;
  logic        rxv32 = 1'b0;
  logic [2:0]  rxs32 = '0;
  logic        ts_valid32, ts_type32, link_pad32, lane_pad32, eios32, err32;
  logic [7:0]  link32, lane32, nfts32, rate32, ctl32;
  logic [1:0]  cnt32;

  rx_os_decoder #(.PIPEWIDTH(8), .CNT_W(4)) dut8 (
    .pclk(clk), .reset(reset), .RxData(rxd8), .RxDataK(rxk8), .RxValid(rxv8),
    .RxStatus(rxs8), .ts_valid(ts_valid8), .ts_type(ts_type8),
    .link_num(link8), .link_pad(link_pad8), .lane_num(lane8),
    .lane_pad(lane_pad8), .n_fts(nfts8), .rate_id(rate8), .train_ctl(ctl8),
    .consec_cnt(cnt8), .eios_det(eios8), .os_err(err8)
  );

  rx_os_decoder #(.PIPEWIDTH(32), .CNT_W(2)) dut32 (
    .pclk(clk), .reset(reset), .RxData(rxd32), .RxDataK(rxk32), .RxValid(rxv32),
    .RxStatus(rxs32), .ts_valid(ts_valid32), .ts_type(ts_type32),
    .link_num(link32), .link_pad(link_pad32), .lane_num(lane32),
    .lane_pad(lane_pad32), .n_fts(nfts32), .rate_id(rate32), .train_ctl(ctl32),
    .consec_cnt(cnt32), .eios_det(eios32), .os_err(err32)
  );

  logic [42:0] vec8, vec32;
  assign vec8  = {ts_type8, link_pad8, link8, lane_pad8, lane8, nfts8, rate8, ctl8};
  assign vec32 = {ts_type32, link_pad32, link32, lane_pad32, lane32, nfts32, rate32, ctl32};

  exp_t exp8[$];
  exp_t exp32[$];
  logic [8:0] sq32[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic os_t make_ts(input logic t2, input logic lpad, input logic [7:0] link,
                                  input logic npad, input logic [7:0] lane,
                                  input logic [7:0] nfts, input logic [7:0] rate,
                                  input logic [7:0] ctl);
    os_t s;
    s[0] = {1'b1, COM};
    s[1] = lpad ? {1'b1, PAD} : {1'b0, link};
    s[2] = npad ? {1'b1, PAD} : {1'b0, lane};
    s[3] = {1'b0, nfts};
    s[4] = {1'b0, rate};
    s[5] = {1'b0, ctl};
    for (int i = 6; i < 16; i++) s[i] = {1'b0, (t2 ? ID2 : ID1)};
    return s;
  endfunction

  function automatic logic [42:0] ts_vec(input logic t2, input logic lpad, input logic [7:0] link,
                                         input logic npad, input logic [7:0] lane,
                                         input logic [7:0] nfts, input logic [7:0] rate,
                                         input logic [7:0] ctl);
    return {t2, lpad, (lpad ? 8'h00 : link), npad, (npad ? 8'h00 : lane), nfts, rate, ctl};
  endfunction

  function automatic exp_t mk_exp(input logic ts, input logic eios, input logic err,
                                  input logic [42:0] f, input int cnt, input int gap);
    exp_t e;
    e.ts = ts; e.eios = eios; e.err = err; e.f = f; e.cnt = cnt; e.gap = gap;
    return e;
  endfunction

  // One 8-bit beat; returns one time unit after the edge that sampled it.
  task automatic sym8(input logic k, input logic [7:0] d, input logic [2:0] st = 3'b000);
    rxv8 = 1'b1; rxk8 = k; rxd8 = d; rxs8 = st;
    @(posedge clk); #1;
    rxv8 = 1'b0; rxs8 = 3'b000;
  endtask

  task automatic send8(input os_t s, input int from, input int to);
    for (int i = from; i <= to; i++) sym8(s[i][8], s[i][7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_os(input os_t s);
    for (int i = 0; i < 16; i++) sq32.push_back(s[i]);
  endtask

  task automatic push_sym(input logic k, input logic [7:0] d);
    sq32.push_back({k, d});
  endtask

  // Drive n 32-bit beats from the symbol queue, earliest symbol in byte 0.
  task automatic flush32(input int n);
    logic [8:0] s;
    repeat (n) begin
      for (int j = 0; j < 4; j++) begin
        s = sq32.pop_front();
        rxk32[j] = s[8];
        rxd32[8*j +: 8] = s[7:0];
      end
      rxv32 = 1'b1;
      @(posedge clk); #1;
      rxv32 = 1'b0;
    end
  endtask

  // Scoreboard monitors: every pulse must match the next expected event.
  exp_t e8, e32;
  int last_ts8 = 0;
  always @(negedge clk) begin
    if (!reset && (ts_valid8 || eios8 || err8)) begin
      if (exp8.size() == 0) begin
        check("dut8_unexpected", 64'({ts_valid8, eios8, err8}), 64'(0));
      end else begin
        e8 = exp8.pop_front();
        check("dut8_kind", 64'({ts_valid8, eios8, err8}), 64'({e8.ts, e8.eios, e8.err}));
        check("dut8_cnt", 64'(cnt8), 64'(e8.cnt));
        if (e8.ts) check("dut8_fields", 64'(vec8), 64'(e8.f));
        if (e8.gap != 0) check("dut8_gap", 64'(cyc - last_ts8), 64'(e8.gap));
        if (ts_valid8) last_ts8 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (ts_valid32 || eios32 || err32)) begin
      if (exp32.size() == 0) begin
        check("dut32_unexpected", 64'({ts_valid32, eios32, err32}), 64'(0));
      end else begin
        e32 = exp32.pop_front();
        check("dut32_kind", 64'({ts_valid32, eios32, err32}), 64'({e32.ts, e32.eios, e32.err}));
        check("dut32_cnt", 64'(cnt32), 64'(e32.cnt));
        if (e32.ts) check("dut32_fields", 64'(vec32), 64'(e32.f));
      end
    end
  end

  os_t a, a_bad, b, c, d;
  logic [42:0] fa, fb, fc, fd;

  initial begin
    a  = make_ts(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h10, 8'h02, 8'h00);
    fa = ts_vec(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h10, 8'h02, 8'h00);
    b  = make_ts(1'b0, 1'b0, 8'h01, 1'b0, 8'h02, 8'h20, 8'h02, 8'h01);
    fb = ts_vec(1'b0, 1'b0, 8'h01, 1'b0, 8'h02, 8'h20, 8'h02, 8'h01);
    c  = make_ts(1'b1, 1'b0, 8'h05, 1'b0, 8'h03, 8'h18, 8'h02, 8'h00);
    fc = ts_vec(1'b1, 1'b0, 8'h05, 1'b0, 8'h03, 8'h18, 8'h02, 8'h00);
    d  = make_ts(1'b1, 1'b1, 8'h00, 1'b0, 8'h07, 8'h18, 8'h02, 8'h00);
    fd = ts_vec(1'b1, 1'b1, 8'h00, 1'b0, 8'h07, 8'h18, 8'h02, 8'h00);
    a_bad    = a;
    a_bad[9] = {1'b0, ID2};

    // Reset state of both instances
    idle(3);
    @(negedge clk);
    check("reset_dut8",  64'({ts_valid8, eios8, err8, cnt8, vec8}), 64'(0));
    check("reset_dut32", 64'({ts_valid32, eios32, err32, cnt32, vec32}), 64'(0));
    reset = 1'b0;
    idle(2);

    // Eight back-to-back identical TS1s: count 1..8, pulses 16 cycles apart
    for (int n = 1; n <= 8; n++) begin
      exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, n, (n == 1) ? 0 : 16));
      send8(a, 0, 15);
    end
    idle(2);

    // Bad identifier at symbol 9: error, tail dropped, next TS1 restarts at 1
    exp8.push_back(mk_exp(1'b0, 1'b0, 1'b1, fa, 0, 0));
    send8(a_bad, 0, 15);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 1, 0));
    send8(a, 0, 15);

    // Two more identical TS1s then EIOS clears the count
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 2, 0));
    send8(a, 0, 15);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 3, 0));
    send8(a, 0, 15);
    exp8.push_back(mk_exp(1'b0, 1'b1, 1'b0, fa, 0, 0));
    sym8(1'b1, COM); sym8(1'b1, IDL); sym8(1'b1, IDL); sym8(1'b1, IDL);
    idle(2);

    // SKP OSs and an idle gap inside a TS do not disturb the count
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 1, 0));
    send8(a, 0, 15);
    sym8(1'b1, COM); sym8(1'b1, SKP); sym8(1'b1, SKP); sym8(1'b1, SKP);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 2, 0));
    send8(a, 0, 5);
    idle(3);
    send8(a, 6, 15);
    sym8(1'b1, COM); sym8(1'b1, SKP); sym8(1'b1, SKP);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 3, 0));
    send8(a, 0, 15);

    // Decode error mid-OS reports; decode error in HUNT is silent
    exp8.push_back(mk_exp(1'b0, 1'b0, 1'b1, fa, 0, 0));
    send8(a, 0, 4);
    sym8(1'b0, ID1, 3'b100);
    idle(2);
    sym8(1'b1, COM, 3'b100);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fa, 1, 0));
    send8(a, 0, 15);

    // COM at symbol 8 resynchronises straight into the following TS1
    exp8.push_back(mk_exp(1'b0, 1'b0, 1'b1, fa, 0, 0));
    send8(b, 0, 7);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fb, 1, 0));
    send8(b, 0, 15);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fb, 2, 0));
    send8(b, 0, 15);

    // Reset at symbol 7 clears everything and discards the partial TS
    send8(b, 0, 6);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midos_reset_dut8", 64'({ts_valid8, eios8, err8, cnt8, vec8}), 64'(0));
    reset = 1'b0;
    idle(1);
    send8(b, 7, 15);
    exp8.push_back(mk_exp(1'b1, 1'b0, 1'b0, fb, 1, 0));
    send8(b, 0, 15);
    idle(3);

    // 32-bit: TS2 with explicit latency check, then saturation at 3
    exp32.push_back(mk_exp(1'b1, 1'b0, 1'b0, fc, 1, 0));
    push_os(c);
    flush32(3);
    @(negedge clk);
    check("ts2_early", 64'(ts_valid32), 64'(0));
    flush32(1);
    @(negedge clk);
    check("ts2_latency", 64'(ts_valid32), 64'(1));
    exp32.push_back(mk_exp(1'b1, 1'b0, 1'b0, fc, 2, 0));
    exp32.push_back(mk_exp(1'b1, 1'b0, 1'b0, fc, 3, 0));
    exp32.push_back(mk_exp(1'b1, 1'b0, 1'b0, fc, 3, 0));
    push_os(c); push_os(c); push_os(c);
    flush32(12);

    // Misaligned TS2 completing in the same beat as a COM,COM error,
    // followed by an EIOS spanning into the next beat
    push_sym(1'b0, 8'h00);
    push_os(d);
    push_sym(1'b1, COM); push_sym(1'b1, COM); push_sym(1'b1, IDL);
    push_sym(1'b1, IDL); push_sym(1'b1, IDL);
    push_sym(1'b0, 8'h00); push_sym(1'b0, 8'h00);
    exp32.push_back(mk_exp(1'b1, 1'b0, 1'b1, fd, 0, 0));
    exp32.push_back(mk_exp(1'b0, 1'b1, 1'b0, fd, 0, 0));
    flush32(6);

    // Bounded drain of both scoreboards
    for (int i = 0; i < 200 && (exp8.size() != 0 || exp32.size() != 0); i++) @(negedge clk);
    idle(4);
    check("sb8_drained",  64'(exp8.size()),  64'(0));
    check("sb32_drained", 64'(exp32.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
